// File: rtl/pc_source_ctrl.sv
// -----------------------------------------------------------------------------
// pc_source_ctrl
//
// Owns the PC-source select and the PC write strobe of a multi-cycle MIPS
// datapath. Normal next-PC requests from the main control unit (jump target,
// EPC return, ALUOut) produce a single registered PCWrite pulse with the
// matching PCSource. An exception runs the entry sequence:
//   EXC_EPC  : ALU computes PC-4, EPC is written
//   EXC_MEM  : vector byte is read from the cause-specific vector address
//   EXC_LOAD : PC is loaded from the sign-extended vector byte (PCSource=11)
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   req_valid     in   next-PC request from main control
//   req_kind      in   00 jump (SL), 01 EPC return, 10 ALUOut, 11 illegal
//   req_ready     out  request accepted this cycle (combinational)
//   exc_opcode    in   invalid-opcode exception pulse
//   exc_ovf       in   overflow exception pulse
//   exc_div       in   divide-by-zero exception pulse
//   PCSource      out  PC mux select: 00 SL, 01 EPC, 10 ALUOut, 11 SE8_32
//   PCWrite       out  PC load strobe
//   EPCWrite      out  EPC load strobe
//   alu_pc_minus4 out  forces the ALU to compute PC-4 during the EPC save
//   exc_mem_read  out  memory read request for the vector byte
//   exc_addr      out  vector byte address (held until the next exception)
//   exc_cause     out  latched cause: 00 none, 01 opcode, 10 ovf, 11 div
//   busy          out  high in any state other than IDLE
//   exc_lost      out  sticky: an exception arrived while busy
// -----------------------------------------------------------------------------
module pc_source_ctrl #(
  parameter int          MEM_LAT = 2,
  parameter logic [31:0] VEC_OPC = 32'd254,
  parameter logic [31:0] VEC_OVF = 32'd253,
  parameter logic [31:0] VEC_DIV = 32'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_kind,
  output logic        req_ready,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div,
  output logic [1:0]  PCSource,
  output logic        PCWrite,
  output logic        EPCWrite,
  output logic        alu_pc_minus4,
  output logic        exc_mem_read,
  output logic [31:0] exc_addr,
  output logic [1:0]  exc_cause,
  output logic        busy,
  output logic        exc_lost
);

  // Sequencer states
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_EXC_EPC  = 2'd1;
  localparam logic [1:0] ST_EXC_MEM  = 2'd2;
  localparam logic [1:0] ST_EXC_LOAD = 2'd3;

  // Cause encodings
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_OPC  = 2'b01;
  localparam logic [1:0] CAUSE_OVF  = 2'b10;
  localparam logic [1:0] CAUSE_DIV  = 2'b11;

  localparam logic [1:0] SRC_SE8_32 = 2'b11;
  localparam logic [1:0] KIND_ILL   = 2'b11;

  // Counter reload value; MEM_LAT is limited to 1..7 so three bits suffice
  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  // Priority select of the cause: opcode > overflow > divide. An illegal
  // request kind is reported as an invalid opcode but only when no real
  // exception input is high.
  function automatic logic [1:0] sel_cause(input logic opc, input logic ovf,
                                           input logic div, input logic ill);
    logic [1:0] c;
    if (opc) begin
      c = CAUSE_OPC;
    end else if (ovf) begin
      c = CAUSE_OVF;
    end else if (div) begin
      c = CAUSE_DIV;
    end else if (ill) begin
      c = CAUSE_OPC;
    end else begin
      c = CAUSE_NONE;
    end
    return c;
  endfunction

  // Vector byte address for a given cause
  function automatic logic [31:0] sel_vector(input logic [1:0] cause);
    logic [31:0] a;
    case (cause)
      CAUSE_OPC: a = VEC_OPC;
      CAUSE_OVF: a = VEC_OVF;
      CAUSE_DIV: a = VEC_DIV;
      default:   a = 32'd0;
    endcase
    return a;
  endfunction

  logic [1:0]  r_state;
  logic [2:0]  r_lat_cnt;
  logic [1:0]  r_pc_source;
  logic        r_pc_write;
  logic        r_epc_write;
  logic        r_alu_pc_minus4;
  logic        r_mem_read;
  logic [31:0] r_exc_addr;
  logic [1:0]  r_exc_cause;
  logic        r_busy;
  logic        r_exc_lost;

  logic        w_exc_any;
  logic        w_idle;
  logic        w_illegal_req;
  logic [1:0]  w_state_nxt;
  logic [2:0]  w_lat_cnt_nxt;
  logic [1:0]  w_pc_source_nxt;
  logic        w_pc_write_nxt;
  logic        w_epc_write_nxt;
  logic        w_alu_pc_minus4_nxt;
  logic        w_mem_read_nxt;
  logic [31:0] w_exc_addr_nxt;
  logic [1:0]  w_exc_cause_nxt;
  logic        w_exc_lost_nxt;
  logic [1:0]  w_cause_sel;

  assign w_exc_any     = exc_opcode | exc_ovf | exc_div;
  assign w_idle        = (r_state == ST_IDLE);
  assign w_illegal_req = req_valid & (req_kind == KIND_ILL);
  assign w_cause_sel   = sel_cause(exc_opcode, exc_ovf, exc_div, w_illegal_req);

  assign req_ready = w_idle & ~w_exc_any;

  // Next state and next registered outputs. Outputs are computed for the
  // state being entered so every strobe appears registered in that state.
  always_comb begin
    w_state_nxt         = r_state;
    w_lat_cnt_nxt       = r_lat_cnt;
    w_pc_source_nxt     = r_pc_source;
    w_pc_write_nxt      = 1'b0;
    w_epc_write_nxt     = 1'b0;
    w_alu_pc_minus4_nxt = 1'b0;
    w_mem_read_nxt      = 1'b0;
    w_exc_addr_nxt      = r_exc_addr;
    w_exc_cause_nxt     = r_exc_cause;
    w_exc_lost_nxt      = r_exc_lost;

    case (r_state)
      ST_IDLE: begin
        if (w_exc_any || w_illegal_req) begin
          // Exceptions win over any request presented in the same cycle
          w_exc_cause_nxt     = w_cause_sel;
          w_exc_addr_nxt      = sel_vector(w_cause_sel);
          w_state_nxt         = ST_EXC_EPC;
          w_epc_write_nxt     = 1'b1;
          w_alu_pc_minus4_nxt = 1'b1;
        end else if (req_valid) begin
          w_pc_write_nxt  = 1'b1;
          w_pc_source_nxt = req_kind;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXC_EPC: begin
        w_state_nxt    = ST_EXC_MEM;
        w_lat_cnt_nxt  = LAT_INIT;
        w_mem_read_nxt = 1'b1;
      end
      ST_EXC_MEM: begin
        if (r_lat_cnt == 3'd1) begin
          w_state_nxt     = ST_EXC_LOAD;
          w_lat_cnt_nxt   = 3'd0;
          w_pc_write_nxt  = 1'b1;
          w_pc_source_nxt = SRC_SE8_32;
        end else begin
          w_lat_cnt_nxt  = r_lat_cnt - 3'd1;
          w_mem_read_nxt = 1'b1;
        end
      end
      ST_EXC_LOAD: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Exceptions that arrive outside IDLE are dropped but remembered
    if (!w_idle && w_exc_any) begin
      w_exc_lost_nxt = 1'b1;
    end else begin
      w_exc_lost_nxt = r_exc_lost;
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_lat_cnt       <= 3'd0;
      r_pc_source     <= 2'b00;
      r_pc_write      <= 1'b0;
      r_epc_write     <= 1'b0;
      r_alu_pc_minus4 <= 1'b0;
      r_mem_read      <= 1'b0;
      r_exc_addr      <= 32'd0;
      r_exc_cause     <= CAUSE_NONE;
      r_busy          <= 1'b0;
      r_exc_lost      <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_lat_cnt       <= w_lat_cnt_nxt;
      r_pc_source     <= w_pc_source_nxt;
      r_pc_write      <= w_pc_write_nxt;
      r_epc_write     <= w_epc_write_nxt;
      r_alu_pc_minus4 <= w_alu_pc_minus4_nxt;
      r_mem_read      <= w_mem_read_nxt;
      r_exc_addr      <= w_exc_addr_nxt;
      r_exc_cause     <= w_exc_cause_nxt;
      r_busy          <= (w_state_nxt != ST_IDLE);
      r_exc_lost      <= w_exc_lost_nxt;
    end
  end

  assign PCSource      = r_pc_source;
  assign PCWrite       = r_pc_write;
  assign EPCWrite      = r_epc_write;
  assign alu_pc_minus4 = r_alu_pc_minus4;
  assign exc_mem_read  = r_mem_read;
  assign exc_addr      = r_exc_addr;
  assign exc_cause     = r_exc_cause;
  assign busy          = r_busy;
  assign exc_lost      = r_exc_lost;

endmodule

// File: tb/tb_pc_source_ctrl.sv
// Scoreboard bench for pc_source_ctrl. The stimulus process drives one cycle
// at a time and a reference model schedules the strobes each accepted event
// must produce (cycle number plus expected output values). A monitor on the
// falling edge pops those entries whenever the DUT shows a strobe.
module tb_pc_source_ctrl;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_kind;
  logic        req_ready;
  logic        exc_opcode, exc_ovf, exc_div;
  logic [1:0]  PCSource;
  logic        PCWrite, EPCWrite, alu_pc_minus4, exc_mem_read;
  logic [31:0] exc_addr;
  logic [1:0]  exc_cause;
  logic        busy, exc_lost;

  always #5 clk = ~clk;

  pc_source_ctrl #(.MEM_LAT(L)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_kind(req_kind),
    .req_ready(req_ready), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf),
    .exc_div(exc_div), .PCSource(PCSource), .PCWrite(PCWrite),
    .EPCWrite(EPCWrite), .alu_pc_minus4(alu_pc_minus4),
    .exc_mem_read(exc_mem_read), .exc_addr(exc_addr), .exc_cause(exc_cause),
    .busy(busy), .exc_lost(exc_lost)
  );

  typedef struct {
    int          cyc;
    logic        pcw;
    logic [1:0]  src;
    logic        epcw;
    logic        m4;
    logic        rd;
    logic [31:0] addr;
    logic [1:0]  cause;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  errs = 0;
  int  checks = 0;
  bit  mon_en = 1'b0;

  // Reference model state
  int          busy_end = -1;
  logic [1:0]  m_src   = 2'd0;
  logic [1:0]  m_cause = 2'd0;
  logic [31:0] m_addr  = 32'd0;
  bit          m_lost  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic pcw, input logic [1:0] src,
                      input logic epcw, input logic m4, input logic rd);
    ev_t e;
    e.cyc = c; e.pcw = pcw; e.src = src; e.epcw = epcw; e.m4 = m4; e.rd = rd;
    e.addr = m_addr; e.cause = m_cause;
    q.push_back(e);
  endtask

  task automatic model_reset();
    busy_end = -1; m_src = 2'd0; m_cause = 2'd0; m_addr = 32'd0; m_lost = 1'b0;
  endtask

  // Drive one cycle of inputs, check the cycle-level outputs and let the
  // model schedule the resulting strobes.
  task automatic step(input logic v, input logic [1:0] k, input logic o,
                      input logic ov, input logic d);
    int  t;
    bit  idle;
    bit  anyx;
    @(posedge clk);
    #1;
    req_valid = v; req_kind = k; exc_opcode = o; exc_ovf = ov; exc_div = d;
    #1;
    t    = cyc;
    idle = (t > busy_end);
    anyx = o | ov | d;
    chk("req_ready", {31'd0, req_ready}, {31'd0, idle && !anyx});
    chk("busy", {31'd0, busy}, {31'd0, !idle});
    chk("exc_lost", {31'd0, exc_lost}, {31'd0, m_lost});
    if (idle) begin
      if (anyx || (v && k == 2'd3)) begin
        if (o)       m_cause = 2'd1;
        else if (ov) m_cause = 2'd2;
        else if (d)  m_cause = 2'd3;
        else         m_cause = 2'd1;
        m_addr = (m_cause == 2'd1) ? 32'd254 : (m_cause == 2'd2) ? 32'd253 : 32'd255;
        push(t + 1, 1'b0, m_src, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < L; i++) push(t + 2 + i, 1'b0, m_src, 1'b0, 1'b0, 1'b1);
        m_src = 2'd3;
        push(t + 2 + L, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        busy_end = t + 2 + L;
      end else if (v) begin
        m_src = k;
        push(t + 1, 1'b1, k, 1'b0, 1'b0, 1'b0);
      end
    end else if (anyx) begin
      m_lost = 1'b1;
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare each strobe cycle against the oldest scheduled entry
  always @(negedge clk) begin
    ev_t e;
    if (mon_en && reset) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_event_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (PCWrite || EPCWrite || exc_mem_read || alu_pc_minus4) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", {28'd0, PCWrite, EPCWrite, exc_mem_read, alu_pc_minus4}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("PCWrite", {31'd0, PCWrite}, {31'd0, e.pcw});
          chk("PCSource", {30'd0, PCSource}, {30'd0, e.src});
          chk("EPCWrite", {31'd0, EPCWrite}, {31'd0, e.epcw});
          chk("alu_pc_minus4", {31'd0, alu_pc_minus4}, {31'd0, e.m4});
          chk("exc_mem_read", {31'd0, exc_mem_read}, {31'd0, e.rd});
          chk("exc_addr", exc_addr, e.addr);
          chk("exc_cause", {30'd0, exc_cause}, {30'd0, e.cause});
        end
      end
      chk("pcw_epcw_exclusive", {31'd0, PCWrite & EPCWrite}, 32'd0);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_PCWrite"}, {31'd0, PCWrite}, 32'd0);
    chk({tag, "_PCSource"}, {30'd0, PCSource}, 32'd0);
    chk({tag, "_EPCWrite"}, {31'd0, EPCWrite}, 32'd0);
    chk({tag, "_alu_pc_minus4"}, {31'd0, alu_pc_minus4}, 32'd0);
    chk({tag, "_exc_mem_read"}, {31'd0, exc_mem_read}, 32'd0);
    chk({tag, "_exc_addr"}, exc_addr, 32'd0);
    chk({tag, "_exc_cause"}, {30'd0, exc_cause}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_exc_lost"}, {31'd0, exc_lost}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_kind = 2'd0;
    exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;
    mon_en = 1'b1;

    // Reset release: ready immediately
    idle_n(2);

    // Back-to-back normal requests: ALUOut, jump, EPC return
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    idle_n(2);

    // Overflow exception sequence
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    idle_n(6);
    chk("ovf_cause_held", {30'd0, exc_cause}, 32'd2);
    chk("ovf_addr_held", exc_addr, 32'd253);

    // Simultaneous div + ovf + ALUOut request: ovf wins, request dropped
    step(1'b1, 2'd2, 1'b0, 1'b1, 1'b1);
    idle_n(6);

    // Illegal request kind behaves like an invalid opcode
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    idle_n(6);
    chk("ill_cause_held", {30'd0, exc_cause}, 32'd1);

    // Exception during EXC_MEM is lost; request held by requester while busy
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    idle_n(3);
    chk("lost_sticky", {31'd0, exc_lost}, 32'd1);

    // Reset asserted in the middle of EXC_MEM
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    idle_n(2);
    mon_en = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk_all_zero("midreset");
    q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    mon_en = 1'b1;
    idle_n(4);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)),
           $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 24) == 0);
    end
    idle_n(10);
    chk("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pc_source_ctrl.md
Name: pc_source_ctrl

Overview:
- Sequencer that owns the PC-source selection and PC write strobe in the multi-cycle MIPS datapath.
- Accepts next-PC requests from the main control unit: jump target (shift-left path), EPC return, or ALUOut for PC+4 and branches. It then drives PCSource and PCWrite.
- On an exception it runs the entry sequence: save PC-4 into EPC, read the handler byte from the vector address, then load PC from the sign-extended byte.

Parameters:
- MEM_LAT, 2, memory read latency in cycles (1..7) from exc_mem_read assertion to valid data at the SE8_32 input
- VEC_OPC, 32'd254, vector byte address for invalid opcode
- VEC_OVF, 32'd253, vector byte address for overflow
- VEC_DIV, 32'd255, vector byte address for divide-by-zero

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  next-PC request from main control
- req_kind  in  2  00 jump (SL), 01 EPC return, 10 ALUOut, 11 illegal
- req_ready  out  1  request accepted this cycle when req_valid is high
- exc_opcode  in  1  invalid-opcode exception pulse
- exc_ovf  in  1  overflow exception pulse
- exc_div  in  1  divide-by-zero exception pulse
- PCSource  out  2  select for the PC source mux: 00 SL, 01 EPC, 10 ALUOut, 11 SE8_32
- PCWrite  out  1  PC load strobe
- EPCWrite  out  1  EPC load strobe
- alu_pc_minus4  out  1  forces the ALU to compute PC-4 during EPC save
- exc_mem_read  out  1  memory read request for the vector byte
- exc_addr  out  32  vector address, valid while exc_mem_read is high
- exc_cause  out  2  latched cause: 00 none, 01 opcode, 10 ovf, 11 div
- busy  out  1  high in any state other than IDLE
- exc_lost  out  1  sticky flag: an exception arrived while busy

Behaviour:
- All outputs are registered. Reset (reset=0) asynchronously forces state IDLE and every output to 0; exc_addr and exc_cause are also 0. Reset takes effect mid-sequence with no partial strobes afterwards.
- req_ready = (state==IDLE) and no exception input high. It is combinational from state and the exception inputs.
- State IDLE:
  - Any exception input high: latch cause with priority opcode > ovf > div, set exc_addr to the matching VEC_*, go to EXC_EPC. req_valid is ignored that cycle.
  - Otherwise, req_valid with req_kind 00/01/10: the next cycle drives PCWrite=1 for exactly 1 cycle, with PCSource=req_kind. State stays IDLE, so back-to-back requests are accepted every cycle.
  - req_valid with req_kind 11: treated as an invalid-opcode exception (cause 01, VEC_OPC, go to EXC_EPC). No PCWrite is issued.
- State EXC_EPC (1 cycle): alu_pc_minus4=1, EPCWrite=1. Next state is EXC_MEM and the latency counter loads MEM_LAT.
- State EXC_MEM (MEM_LAT cycles): exc_mem_read=1 and exc_addr held. The counter decrements each cycle; at 1, the next state is EXC_LOAD.
- State EXC_LOAD (1 cycle): PCSource=11, PCWrite=1. Next state is IDLE. exc_cause stays held until the next exception or reset.
- Exception latency: first PCWrite lands at cycle 2+MEM_LAT after the exception cycle. EPCWrite is at +1.
- Exception inputs while busy are dropped and set exc_lost. exc_lost is cleared only by reset.
- req_valid while busy: req_ready=0, so the request is held by the requester.
- PCWrite and EPCWrite are never high in the same cycle. PCSource holds its last value when PCWrite=0.

Test Plan:
- Reset: drive reset=0 mid-EXC_MEM -> all outputs 0, state IDLE; after release req_ready=1.
- Normal requests: req_kind 10, 00, 01 on consecutive cycles -> PCWrite=1 for three consecutive cycles with PCSource 10, 00, 01; busy stays 0.
- Overflow with MEM_LAT=2: exc_ovf pulse at cycle T -> EPCWrite and alu_pc_minus4 at T+1; exc_mem_read with exc_addr=253 at T+2..T+3; PCWrite with PCSource=11 at T+4; exc_cause=10.
- Simultaneous events: exc_div, exc_ovf and req_valid (kind 10) at T -> cause=10, exc_addr=253, no normal PCWrite at T+1, req_ready=0 at T.
- Illegal kind: req_kind=11 -> cause=01, exc_addr=254, full exception sequence, no PCWrite with PCSource 11 until EXC_LOAD.
- Lost exception: exc_opcode during EXC_MEM -> exc_lost=1; sequence completes unchanged with the original cause and address.
